lsu_mem_port: RTL

//  Load/store initiator for the data port of the core's synchronous dual-port RAM.

---
 rtl/lsu_mem_port.sv | 134 +++++++++++++
 1 files changed

// File: rtl/lsu_mem_port.sv
// RV32I load/store initiator for the data port of a synchronous RAM.
// One request in flight; loads answer in 2 cycles, stores/errors in 1.
module lsu_mem_port #(
  parameter int ADDR_WIDTH = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] d_addr,
  output logic                  d_we,
  output logic [3:0]            d_be,
  output logic [31:0]           d_wdata,
  input  logic [31:0]           d_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD_WAIT,
    RESP
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  off;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;
  logic        err;
  logic        accept;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic        unused_addr;

  assign off         = req_addr[1:0];
  assign unused_addr = ^req_addr[31:ADDR_WIDTH+2];
  assign d_addr      = req_addr[ADDR_WIDTH+1:2];
  assign req_ready   = (state == IDLE) & ~reset;
  assign accept      = req_valid & req_ready;
  assign d_we        = accept & req_we & ~err;
  assign rsp_valid   = (state == RESP);

  always_comb begin
    err = 1'b0;
    unique case (req_funct3)
      3'b000:         err = 1'b0;
      3'b001:         err = off[0];
      3'b010:         err = |off;
      3'b100, 3'b101: err = req_we;
      default:        err = 1'b1;
    endcase
  end

  always_comb begin
    d_be    = 4'hF;
    d_wdata = req_wdata;
    unique case (req_funct3[1:0])
      2'b00: begin
        d_be    = 4'b0001 << off;
        d_wdata = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        d_be    = 4'b0011 << off;
        d_wdata = {2{req_wdata[15:0]}};
      end
      default: begin
        d_be    = 4'hF;
        d_wdata = req_wdata;
      end
    endcase
  end

  // Lane selection uses the offset captured at accept, not the live inputs
  always_comb begin
    ld_byte = d_rdata[7:0];
    unique case (off_q)
      2'd0: ld_byte = d_rdata[7:0];
      2'd1: ld_byte = d_rdata[15:8];
      2'd2: ld_byte = d_rdata[23:16];
      2'd3: ld_byte = d_rdata[31:24];
    endcase
    ld_half = off_q[1] ? d_rdata[31:16] : d_rdata[15:0];
    ld_data = d_rdata;
    unique case (f3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'h0, ld_byte};
      3'b101:  ld_data = {16'h0, ld_half};
      default: ld_data = d_rdata;
    endcase
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = (req_we | err) ? RESP : LOAD_WAIT;
        end
      end
      LOAD_WAIT: state_nxt = RESP;
      RESP:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      off_q     <= 2'd0;
      f3_q      <= 3'd0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        off_q     <= off;
        f3_q      <= req_funct3;
        rsp_err   <= err;
        rsp_rdata <= 32'h0;
      end else if (state == LOAD_WAIT) begin
        rsp_rdata <= ld_data;
      end
    end
  end

endmodule
